// File: rtl/task_trace_pkg.sv
// task_trace_pkg: shared constants and types for the task trace monitor.
// Record layout, MSB to LSB: {start_cycle, length, task_id}.
package task_trace_pkg;

  localparam int ID_W = 16;
  localparam logic [ID_W-1:0] IDLE_ID = 16'hFFFF;

  localparam int TS_W_DEF  = 16;
  localparam int LEN_W_DEF = 8;

  localparam int ID_LSB  = 0;
  localparam int LEN_LSB = ID_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int ts_lsb(input int len_w);
    return ID_W + len_w;
  endfunction

  function automatic int rec_w(input int ts_w, input int len_w);
    return ts_w + len_w + ID_W;
  endfunction

endpackage

// File: rtl/task_trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO. The head entry is presented
// combinationally; a push into a full FIFO succeeds only with a same-cycle pop.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/task_trace_monitor.sv
// task_trace_monitor: turns the scheduler's per-cycle task stream into
// run-length records {start_cycle, length, task_id} buffered in a FIFO.
// Optional macro TRACE_IDLE_REC_EN: when defined, idle runs are recorded too.
module task_trace_monitor
  import task_trace_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TS_W      = TS_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int DONE_IDLE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st,
  input  logic [ID_W-1:0]         task_in,
  input  logic                    empty_in,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [TS_W+LEN_W+ID_W-1:0] rec_data,
  output logic                    done,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam int REC_W = rec_w(TS_W, LEN_W);
  localparam int IW    = $clog2(DONE_IDLE + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
`ifdef TRACE_IDLE_REC_EN
  localparam bit IDLE_PUSH = 1'b1;
`else
  localparam bit IDLE_PUSH = 1'b0;
`endif

  state_t            state, state_n;
  logic [TS_W-1:0]   cyc, cyc_n;
  logic              run_open, run_open_n;
  logic [ID_W-1:0]   run_id, run_id_n;
  logic [TS_W-1:0]   run_start, run_start_n;
  logic [LEN_W-1:0]  run_len, run_len_n;
  logic [IW-1:0]     idle_cnt, idle_n;
  logic              pend_valid, pend_valid_n;
  logic [REC_W-1:0]  pend_rec, pend_rec_n;
  logic              push;
  logic [REC_W-1:0]  push_rec;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  function automatic logic pushable(input logic [ID_W-1:0] id);
    return IDLE_PUSH || (id != IDLE_ID);
  endfunction

  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign drop      = push && fifo_full && !pop;
  assign done      = (state == S_DONE) && !pend_valid;

  // Next-state logic: run coalescing, done detection and record pushes.
  // When the last idle sample both splits a saturated run and ends the
  // schedule, the final record is parked in pend and pushed one cycle later.
  always_comb begin
    state_n      = state;
    cyc_n        = cyc;
    run_open_n   = run_open;
    run_id_n     = run_id;
    run_start_n  = run_start;
    run_len_n    = run_len;
    idle_n       = idle_cnt;
    pend_valid_n = pend_valid;
    pend_rec_n   = pend_rec;
    push         = 1'b0;
    push_rec     = '0;
    case (state)
      S_IDLE: begin
        if (st) begin
          state_n    = S_TRACK;
          cyc_n      = '0;
          run_open_n = 1'b0;
          idle_n     = '0;
        end
      end
      S_TRACK: begin
        cyc_n  = cyc + 1'b1;
        idle_n = (task_in == IDLE_ID && empty_in) ? idle_cnt + 1'b1 : '0;
        if (!run_open) begin
          run_open_n  = 1'b1;
          run_id_n    = task_in;
          run_start_n = cyc;
          run_len_n   = LEN_W'(1);
        end else if (task_in == run_id && run_len != LEN_MAX) begin
          run_len_n = run_len + 1'b1;
        end else begin
          push        = pushable(run_id);
          push_rec    = {run_start, run_len, run_id};
          run_id_n    = task_in;
          run_start_n = cyc;
          run_len_n   = LEN_W'(1);
        end
        if (idle_n == IW'(DONE_IDLE)) begin
          state_n    = S_DONE;
          run_open_n = 1'b0;
          if (pushable(run_id_n)) begin
            if (push) begin
              pend_valid_n = 1'b1;
              pend_rec_n   = {run_start_n, run_len_n, run_id_n};
            end else begin
              push     = 1'b1;
              push_rec = {run_start_n, run_len_n, run_id_n};
            end
          end
        end
      end
      S_DONE: begin
        if (pend_valid) begin
          push         = 1'b1;
          push_rec     = pend_rec;
          pend_valid_n = 1'b0;
        end
        if (st) begin
          state_n    = S_TRACK;
          cyc_n      = '0;
          run_open_n = 1'b0;
          idle_n     = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and open-run registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc        <= '0;
      run_open   <= 1'b0;
      run_id     <= '0;
      run_start  <= '0;
      run_len    <= '0;
      idle_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_rec   <= '0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      run_open   <= run_open_n;
      run_id     <= run_id_n;
      run_start  <= run_start_n;
      run_len    <= run_len_n;
      idle_cnt   <= idle_n;
      pend_valid <= pend_valid_n;
      pend_rec   <= pend_rec_n;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_rec),
    .pop   (pop),
    .dout  (rec_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_task_trace_monitor.sv
// tb_task_trace_monitor: directed self-checking bench. Two instances share the
// stimulus: a default-sized one and a small one (DEPTH=2, LEN_W=2).
// Honours TRACE_IDLE_REC_EN for the idle-record expectation.
module tb_task_trace_monitor;

  localparam logic [15:0] IDLE = 16'hFFFF;
  localparam logic [15:0] TA = 16'h00A0;
  localparam logic [15:0] TB = 16'h00B0;
  localparam logic [15:0] TC = 16'h00C0;
  localparam logic [15:0] TD = 16'h00D0;
  localparam logic [15:0] TE = 16'h00E0;
  localparam logic [15:0] TF = 16'h00F0;
  localparam logic [15:0] TG = 16'h0011;
  localparam logic [15:0] TH = 16'h0022;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st = 1'b0;
  logic [15:0] task_in = IDLE;
  logic        empty_in = 1'b0;
  logic        rec_ready = 1'b0;

  logic        m_valid, m_done, m_ovf;
  logic [39:0] m_data;
  logic [7:0]  m_drop;
  logic        s_valid, s_done, s_ovf;
  logic [33:0] s_data;
  logic [7:0]  s_drop;

  logic [39:0] q_main [$];
  logic [33:0] q_small [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task_trace_monitor #(.DEPTH(8), .TS_W(16), .LEN_W(8), .DONE_IDLE(4)) dut_main (
    .clk(clk), .rst(rst), .st(st), .task_in(task_in), .empty_in(empty_in),
    .rec_valid(m_valid), .rec_ready(rec_ready), .rec_data(m_data),
    .done(m_done), .overflow(m_ovf), .drop_cnt(m_drop)
  );

  task_trace_monitor #(.DEPTH(2), .TS_W(16), .LEN_W(2), .DONE_IDLE(4)) dut_small (
    .clk(clk), .rst(rst), .st(st), .task_in(task_in), .empty_in(empty_in),
    .rec_valid(s_valid), .rec_ready(rec_ready), .rec_data(s_data),
    .done(s_done), .overflow(s_ovf), .drop_cnt(s_drop)
  );

  // Capture every record accepted by the consumer.
  always @(posedge clk) begin
    if (!rst) begin
      if (m_valid && rec_ready) q_main.push_back(m_data);
      if (s_valid && rec_ready) q_small.push_back(s_data);
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; st = 1'b0; task_in = IDLE; empty_in = 1'b0; rec_ready = 1'b0;
    tick();
    rst = 1'b0;
    q_main.delete();
    q_small.delete();
  endtask

  task automatic start();
    st = 1'b1; task_in = IDLE; empty_in = 1'b0;
    tick();
    st = 1'b0;
  endtask

  task automatic drive(input logic [15:0] id, input logic emp, input int n);
    task_in = id; empty_in = emp;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp += 10;
    if (m_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_valid got %b need 0", m_valid); end
    if (m_data !== 40'd0) begin n_bad++; $display("[TB] FAIL reset_m_data got %h need 0", m_data); end
    if (m_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_done got %b need 0", m_done); end
    if (m_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_ovf got %b need 0", m_ovf); end
    if (m_drop !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_m_drop got %0d need 0", m_drop); end
    if (s_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_s_valid got %b need 0", s_valid); end
    if (s_data !== 34'd0) begin n_bad++; $display("[TB] FAIL reset_s_data got %h need 0", s_data); end
    if (s_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_s_done got %b need 0", s_done); end
    if (s_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_s_ovf got %b need 0", s_ovf); end
    if (s_drop !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_s_drop got %0d need 0", s_drop); end
  endtask

  task automatic test_basic_runs();
    int exp_n;
    do_reset();
    rec_ready = 1'b1;
    start();
    drive(TA, 1'b0, 3);
    drive(TB, 1'b0, 2);
    drive(IDLE, 1'b1, 3);
    n_cmp++;
    if (m_done !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_done_early got %b need 0", m_done); end
    drive(IDLE, 1'b1, 1);
    n_cmp++;
    if (m_done !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_done got %b need 1", m_done); end
    drive(IDLE, 1'b1, 3);
`ifdef TRACE_IDLE_REC_EN
    exp_n = 3;
`else
    exp_n = 2;
`endif
    n_cmp++;
    if (q_main.size() !== exp_n) begin n_bad++; $display("[TB] FAIL basic_count got %0d need %0d", q_main.size(), exp_n); end
    if (q_main.size() >= 2) begin
      n_cmp += 2;
      if (q_main[0] !== {16'd0, 8'd3, TA}) begin n_bad++; $display("[TB] FAIL basic_rec0 got %h need %h", q_main[0], {16'd0, 8'd3, TA}); end
      if (q_main[1] !== {16'd3, 8'd2, TB}) begin n_bad++; $display("[TB] FAIL basic_rec1 got %h need %h", q_main[1], {16'd3, 8'd2, TB}); end
    end
`ifdef TRACE_IDLE_REC_EN
    if (q_main.size() >= 3) begin
      n_cmp++;
      if (q_main[2] !== {16'd5, 8'd4, IDLE}) begin n_bad++; $display("[TB] FAIL basic_idle_rec got %h need %h", q_main[2], {16'd5, 8'd4, IDLE}); end
    end
`endif
    n_cmp += 2;
    if (m_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_drained got %b need 0", m_valid); end
    if (m_done !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_done_hold got %b need 1", m_done); end
  endtask

  task automatic test_restart_from_done();
    q_main.delete();
    start();
    n_cmp++;
    if (m_done !== 1'b0) begin n_bad++; $display("[TB] FAIL restart_done got %b need 0", m_done); end
    drive(TG, 1'b0, 2);
    drive(TH, 1'b0, 2);
    n_cmp++;
    if (q_main.size() !== 1) begin n_bad++; $display("[TB] FAIL restart_count got %0d need 1", q_main.size()); end
    if (q_main.size() >= 1) begin
      n_cmp++;
      if (q_main[0] !== {16'd0, 8'd2, TG}) begin n_bad++; $display("[TB] FAIL restart_rec got %h need %h", q_main[0], {16'd0, 8'd2, TG}); end
    end
  endtask

  task automatic test_len_saturation();
    do_reset();
    rec_ready = 1'b1;
    start();
    drive(TC, 1'b0, 7);
    drive(TD, 1'b0, 2);
    n_cmp += 2;
    if (q_small.size() !== 3) begin n_bad++; $display("[TB] FAIL sat_count got %0d need 3", q_small.size()); end
    if (s_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL sat_ovf got %b need 0", s_ovf); end
    if (q_small.size() >= 3) begin
      n_cmp += 3;
      if (q_small[0] !== {16'd0, 2'd3, TC}) begin n_bad++; $display("[TB] FAIL sat_rec0 got %h need %h", q_small[0], {16'd0, 2'd3, TC}); end
      if (q_small[1] !== {16'd3, 2'd3, TC}) begin n_bad++; $display("[TB] FAIL sat_rec1 got %h need %h", q_small[1], {16'd3, 2'd3, TC}); end
      if (q_small[2] !== {16'd6, 2'd1, TC}) begin n_bad++; $display("[TB] FAIL sat_rec2 got %h need %h", q_small[2], {16'd6, 2'd1, TC}); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    start();
    for (int i = 0; i < 3; i++) begin
      drive(TA, 1'b0, 1);
      drive(TB, 1'b0, 1);
    end
    n_cmp += 4;
    if (s_ovf !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_flag got %b need 1", s_ovf); end
    if (s_drop !== 8'd3) begin n_bad++; $display("[TB] FAIL ovf_drop_cnt got %0d need 3", s_drop); end
    if (s_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_valid got %b need 1", s_valid); end
    if (s_data !== {16'd0, 2'd1, TA}) begin n_bad++; $display("[TB] FAIL ovf_head got %h need %h", s_data, {16'd0, 2'd1, TA}); end
    q_small.delete();
    rec_ready = 1'b1;
    drive(TB, 1'b0, 2);
    n_cmp += 2;
    if (q_small.size() !== 2) begin n_bad++; $display("[TB] FAIL ovf_drain_count got %0d need 2", q_small.size()); end
    if (s_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_drain_empty got %b need 0", s_valid); end
    if (q_small.size() >= 2) begin
      n_cmp += 2;
      if (q_small[0] !== {16'd0, 2'd1, TA}) begin n_bad++; $display("[TB] FAIL ovf_drain0 got %h need %h", q_small[0], {16'd0, 2'd1, TA}); end
      if (q_small[1] !== {16'd1, 2'd1, TB}) begin n_bad++; $display("[TB] FAIL ovf_drain1 got %h need %h", q_small[1], {16'd1, 2'd1, TB}); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start();
    drive(TA, 1'b0, 1);
    drive(TB, 1'b0, 1);
    drive(TA, 1'b0, 1);
    n_cmp++;
    if (s_data !== {16'd0, 2'd1, TA}) begin n_bad++; $display("[TB] FAIL b2b_head_full got %h need %h", s_data, {16'd0, 2'd1, TA}); end
    q_small.delete();
    rec_ready = 1'b1;
    drive(TB, 1'b0, 1);
    n_cmp += 4;
    if (s_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_ovf got %b need 0", s_ovf); end
    if (s_drop !== 8'd0) begin n_bad++; $display("[TB] FAIL b2b_drop got %0d need 0", s_drop); end
    if (s_data !== {16'd1, 2'd1, TB}) begin n_bad++; $display("[TB] FAIL b2b_head_adv got %h need %h", s_data, {16'd1, 2'd1, TB}); end
    if (q_small.size() !== 1) begin n_bad++; $display("[TB] FAIL b2b_pop_count got %0d need 1", q_small.size()); end
    drive(TB, 1'b0, 2);
    n_cmp += 2;
    if (q_small.size() !== 3) begin n_bad++; $display("[TB] FAIL b2b_total got %0d need 3", q_small.size()); end
    if (s_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_empty got %b need 0", s_valid); end
    if (q_small.size() >= 3) begin
      n_cmp++;
      if (q_small[2] !== {16'd2, 2'd1, TA}) begin n_bad++; $display("[TB] FAIL b2b_pushed got %h need %h", q_small[2], {16'd2, 2'd1, TA}); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start();
    drive(TA, 1'b0, 1);
    drive(TB, 1'b0, 1);
    drive(TA, 1'b0, 1);
    drive(TB, 1'b0, 1);
    n_cmp += 2;
    if (s_ovf !== 1'b1) begin n_bad++; $display("[TB] FAIL areset_pre_ovf got %b need 1", s_ovf); end
    if (m_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL areset_pre_valid got %b need 1", m_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 6;
    if (m_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_m_valid got %b need 0", m_valid); end
    if (m_done !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_m_done got %b need 0", m_done); end
    if (s_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_s_valid got %b need 0", s_valid); end
    if (s_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_s_ovf got %b need 0", s_ovf); end
    if (s_drop !== 8'd0) begin n_bad++; $display("[TB] FAIL areset_s_drop got %0d need 0", s_drop); end
    if (m_data !== 40'd0) begin n_bad++; $display("[TB] FAIL areset_m_data got %h need 0", m_data); end
    #1;
    rst = 1'b0;
    q_main.delete();
    q_small.delete();
    rec_ready = 1'b1;
    start();
    drive(TE, 1'b0, 2);
    drive(TF, 1'b0, 2);
    n_cmp++;
    if (q_main.size() !== 1) begin n_bad++; $display("[TB] FAIL areset_new_count got %0d need 1", q_main.size()); end
    if (q_main.size() >= 1) begin
      n_cmp++;
      if (q_main[0] !== {16'd0, 8'd2, TE}) begin n_bad++; $display("[TB] FAIL areset_new_rec got %h need %h", q_main[0], {16'd0, 8'd2, TE}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_runs();
    test_restart_from_done();
    test_len_saturation();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/task_trace_monitor.md
Name: task_trace_monitor

Overview:
- Downstream of the round-robin scheduler. Samples the scheduler's per-cycle 16-bit task output and its empty flag.
- Coalesces consecutive identical task IDs into run-length records: start cycle, length, task ID.
- Buffers records in a small FIFO, read out over a valid/ready handshake by the trace/checker logic.
- Detects end of schedule and raises done.

Parameters:
- DEPTH, 8, record FIFO entries (power of 2, ≥2)
- TS_W, 16, cycle-stamp width
- LEN_W, 8, run-length field width
- DONE_IDLE, 4, consecutive idle+empty cycles that declare schedule finished

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- st  in  1  start pulse, same pulse that starts the scheduler
- task_in  in  16  scheduler task output; 16'hFFFF = idle
- empty_in  in  1  scheduler empty flag
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_data  out  TS_W+LEN_W+16  {start_cycle, length, task_id}
- done  out  1  schedule finished, all runs flushed into FIFO
- overflow  out  1  sticky; at least one record dropped
- drop_cnt  out  8  saturating count of dropped records

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on rst. All clocked state clears on rst assertion, including mid-run.
- Reset values: rec_valid=0, rec_data=0, done=0, overflow=0, drop_cnt=0, FIFO empty, state S_IDLE, cycle counter=0, no open run.
- States:
  - S_IDLE: wait for st=1, then go to S_TRACK. Cycle counter stays 0.
  - S_TRACK: cycle counter c increments each cycle; 0 is the first S_TRACK cycle. task_in is sampled every cycle.
  - S_DONE: done=1. No further sampling. FIFO still drains. Leave only on rst, or on st=1 → S_TRACK with counter, run and idle counter cleared. FIFO contents and overflow are kept.
- Run tracking (S_TRACK, sample at cycle c):
  - No open run: open run {id=task_in, start=c, len=1}.
  - task_in == open id and len < 2^LEN_W-1: len++.
  - Otherwise (ID change or len saturated):
    - Push the closed run record at this edge.
    - Open a new run {task_in, c, 1}.
    - A saturated run splits into consecutive records with the same ID.
- Idle runs (id 16'hFFFF) are tracked but never pushed (see optional feature).
- Done detection:
  - An idle counter counts consecutive cycles with task_in==16'hFFFF and empty_in=1; any other cycle resets it to 0.
  - When it reaches DONE_IDLE, close the open run, push it if pushable, and go to S_DONE the next cycle.
- FIFO:
  - rec_valid = FIFO not empty. rec_data = head entry. Output is combinational from storage, so a record is visible the cycle after its push.
  - Pop when rec_valid && rec_ready.
  - Push while full with a pop in the same cycle: both succeed.
  - Push while full with no pop: record dropped, overflow set, drop_cnt++ (saturates at 255).
- Cycle counter wraps at 2^TS_W. start_cycle is taken modulo that.
- st while in S_TRACK is ignored.

Optional Feature:
- Macro: TRACE_IDLE_REC_EN.
- Defined: closed idle runs (id 16'hFFFF) are pushed like any other run. The final idle run is pushed at done.
- Undefined: idle runs are never pushed; their cycles only advance the cycle counter.

Decomposition:
- Package task_trace_pkg holds:
  - IDLE_ID = 16'hFFFF
  - the state encoding (S_IDLE / S_TRACK / S_DONE)
  - the record field width constants and record field offsets
- One sub-module: trace_fifo. Synchronous FIFO with parameters DEPTH and WIDTH, push/pop/full/empty, show-ahead output.
- Run tracking, done detection and drop accounting stay in the top module.

Test Plan:
1. st at c=0, task_in = A×3, B×2, then FFFF with empty_in=1 for 4 cycles, rec_ready=1 → records {0,3,A}, {3,2,B}; done=1 after the 4th idle cycle; no idle record.
2. Same stimulus with TRACE_IDLE_REC_EN defined → additionally {5,4,FFFF}.
3. LEN_W=2, task_in = C for 7 cycles then D → records {0,3,C}, {3,3,C}, {6,1,C} in order.
4. DEPTH=2, rec_ready=0, alternating A/B for 6 cycles → 2 records held, overflow=1, drop_cnt=3. Raise rec_ready → exactly the first two records drain.
5. Full FIFO with push and pop in the same cycle → no drop, occupancy unchanged, head advances.
6. rst asserted mid-S_TRACK, between clock edges → rec_valid, done, overflow and drop_cnt are 0 immediately; after a new st the first record has start_cycle 0.
